niosmp_nios2_processor_ocimem_ctrl: RTL

- Consumes the sysclk-domain JTAG debug command strobes (take_action_ocimem_a/b, take_no_action_ocimem_a) and the 38-bit jdo word.
- Produces MonDReg back to the JTAG debug module; that is the path by which the debugger reads and writes the on-chip debug RAM.
- Arbitrates the same single-port RAM against the CPU-side Avalon-MM slave. JTAG has fixed priority.

---
 rtl/niosmp_nios2_processor_ocimem_ctrl.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/niosmp_nios2_processor_ocimem_ctrl.sv
// niosmp_nios2_processor_ocimem_ctrl
// On-chip debug RAM controller. It shares one single-port RAM between the
// JTAG debug module (MonAReg/MonDReg path) and a CPU-side Avalon-MM slave.
// JTAG has fixed priority. An access that has already started is never
// pre-empted.
// Optional build macro: NIOSMP_OCIMEM_CPU_WRPROTECT_EN. When it is defined,
// CPU writes at or above PROTECT_BASE are acknowledged, are dropped, and
// flag cpu_wr_err.
module niosmp_nios2_processor_ocimem_ctrl #(
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned PROTECT_BASE = 192
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    output logic [31:0]       MonDReg,
    output logic              jtag_busy,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    input  logic [3:0]        avs_byteenable,
    output logic [31:0]       avs_readdata,
    output logic              avs_waitrequest,
    output logic              cpu_wr_err
);

    typedef enum logic [2:0] {
        IDLE, J_WR, J_RD, J_RD_CAP, C_RD, C_RD_CAP
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0] MonAReg;
    logic              pend_addr, pend_addr_rdnow, pend_wr, pend_rd;
    logic [ADDR_W-1:0] pend_addr_val;
    logic [31:0]       pend_wr_data;

    logic              req_addr, req_wr, req_rd, jtag_req;
    logic [ADDR_W-1:0] ld_addr;
    logic              ld_rdnow;
    logic              sel_addr, sel_wr, sel_rd, sel_crd, sel_cwr;
    logic              cpu_wr_prot;

    logic [31:0]       mem [0:(1<<ADDR_W)-1];
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata, ram_q;
    logic [3:0]        ram_be;

    logic              unused_jdo;

    // A strobe seen while IDLE is served in the same cycle it arrives, so it
    // bypasses its latch. The latch only matters when the FSM is busy.
    assign req_addr = pend_addr | take_action_ocimem_a;
    assign req_wr   = pend_wr   | take_action_ocimem_b;
    assign req_rd   = pend_rd   | take_no_action_ocimem_a;
    assign jtag_req = req_addr | req_wr | req_rd;
    assign ld_addr  = take_action_ocimem_a ? jdo[ADDR_W+25:26] : pend_addr_val;
    assign ld_rdnow = take_action_ocimem_a ? jdo[25]           : pend_addr_rdnow;

    assign jtag_busy = pend_addr | pend_wr | pend_rd |
                       (state == J_WR) | (state == J_RD) | (state == J_RD_CAP);

    assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

`ifdef NIOSMP_OCIMEM_CPU_WRPROTECT_EN
    assign cpu_wr_prot = ({{(32-ADDR_W){1'b0}}, avs_address} >= PROTECT_BASE);

    // One-cycle error pulse when a protected CPU write is acknowledged and dropped
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cpu_wr_err <= 1'b0;
        else       cpu_wr_err <= sel_cwr & cpu_wr_prot;
    end
`else
    logic unused_protect_base;
    assign unused_protect_base = (PROTECT_BASE == 0);
    assign cpu_wr_prot = 1'b0;
    assign cpu_wr_err  = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic and IDLE arbitration: JTAG addr, wr, rd, then CPU read, then CPU write
    always_comb begin
        state_nxt = state;
        sel_addr  = 1'b0;
        sel_wr    = 1'b0;
        sel_rd    = 1'b0;
        sel_crd   = 1'b0;
        sel_cwr   = 1'b0;
        case (state)
            IDLE: begin
                if (req_addr) begin
                    sel_addr = 1'b1;
                end else if (req_wr) begin
                    sel_wr    = 1'b1;
                    state_nxt = J_WR;
                end else if (req_rd) begin
                    sel_rd    = 1'b1;
                    state_nxt = J_RD;
                end else if (avs_read) begin
                    sel_crd   = 1'b1;
                    state_nxt = C_RD;
                end else if (avs_write) begin
                    sel_cwr = 1'b1;
                end
            end
            J_WR:     state_nxt = IDLE;
            J_RD:     state_nxt = J_RD_CAP;
            J_RD_CAP: state_nxt = IDLE;
            C_RD:     state_nxt = C_RD_CAP;
            C_RD_CAP: state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // RAM control and Avalon waitrequest. A CPU read is addressed in its accept
    // cycle, so the data is registered by C_RD_CAP and the transfer completes there.
    always_comb begin
        ram_addr        = (state == IDLE) ? avs_address : MonAReg;
        ram_wdata       = avs_writedata;
        ram_be          = '0;
        avs_waitrequest = 1'b0;
        case (state)
            IDLE: begin
                if (sel_cwr && !cpu_wr_prot) ram_be = avs_byteenable;
                if (avs_read)       avs_waitrequest = 1'b1;
                else if (avs_write) avs_waitrequest = jtag_req;
            end
            J_WR: begin
                ram_wdata       = pend_wr_data;
                ram_be          = '1;
                avs_waitrequest = avs_read | avs_write;
            end
            J_RD, J_RD_CAP: avs_waitrequest = avs_read | avs_write;
            C_RD:           avs_waitrequest = 1'b1;
            C_RD_CAP:       avs_waitrequest = 1'b0;
            default:        avs_waitrequest = 1'b0;
        endcase
        if (reset) ram_be = '0;
    end

    // Single-port debug RAM with byte write enables and a registered read
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < 4; i++) begin
            if (ram_be[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
        end
        ram_q <= mem[ram_addr];
    end

    // Pending JTAG latches, monitor registers and CPU read data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_addr       <= 1'b0;
            pend_addr_rdnow <= 1'b0;
            pend_addr_val   <= '0;
            pend_wr         <= 1'b0;
            pend_wr_data    <= '0;
            pend_rd         <= 1'b0;
            MonAReg         <= '0;
            MonDReg         <= '0;
            avs_readdata    <= '0;
        end else begin
            if (take_action_ocimem_a) begin
                pend_addr_val   <= jdo[ADDR_W+25:26];
                pend_addr_rdnow <= jdo[25];
            end
            if (sel_addr)                  pend_addr <= 1'b0;
            else if (take_action_ocimem_a) pend_addr <= 1'b1;

            if (take_action_ocimem_b) pend_wr_data <= jdo[34:3];
            if (sel_wr)                    pend_wr <= 1'b0;
            else if (take_action_ocimem_b) pend_wr <= 1'b1;

            if (sel_addr && ld_rdnow)         pend_rd <= 1'b1;
            else if (sel_rd)                  pend_rd <= 1'b0;
            else if (take_no_action_ocimem_a) pend_rd <= 1'b1;

            case (state)
                IDLE: if (sel_addr) MonAReg <= ld_addr;
                J_WR: begin
                    MonDReg <= pend_wr_data;
                    MonAReg <= MonAReg + 1'b1;
                end
                J_RD_CAP: begin
                    MonDReg <= ram_q;
                    MonAReg <= MonAReg + 1'b1;
                end
                C_RD:    avs_readdata <= ram_q;
                default: ;
            endcase
        end
    end

endmodule
